// File: rtl/wbs_axis_ingress.sv
// Wishbone slave that buffers DATA writes in a small FIFO and replays them as an
// AXI-Stream master, with a programmable frame length driving m_tlast.
module wbs_axis_ingress #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [7:0]  wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        m_tvalid,
    output logic        m_tlast,
    output logic [31:0] m_tdata,
    input  logic        m_tready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 16;

    localparam logic [7:0] ADR_DATA   = 8'h00;
    localparam logic [7:0] ADR_LEN    = 8'h04;
    localparam logic [7:0] ADR_STATUS = 8'h08;

    logic [DW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr, wr_ptr_nx;
    logic [PW-1:0] rd_ptr, rd_ptr_nx;
    logic [CW-1:0] count, count_nx;
    logic [LW-1:0] len, len_nx;
    logic [LW-1:0] beat, beat_nx;

    logic          full, empty;
    logic          req, is_data, is_len, is_status;
    logic          push, pop, flush, len_wr, service;
    logic          tlast_nx;
    logic [DW-1:0] head_nx;
    logic [DW-1:0] reg_rdata;
    logic [DW-1:0] rdata_nx;

    logic          unused_sel;
    assign unused_sel = ^wbs_sel_i[3:2];

    // Request decode; a DATA write is held off while full, judged on the registered count
    always_comb begin
        full      = (count == CW'(DEPTH));
        empty     = (count == '0);
        req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
        is_data   = (wbs_adr_i == ADR_DATA);
        is_len    = (wbs_adr_i == ADR_LEN);
        is_status = (wbs_adr_i == ADR_STATUS);
        push      = req & wbs_we_i & is_data & ~full;
        flush     = req & wbs_we_i & is_status & wbs_dat_i[0];
        len_wr    = req & wbs_we_i & is_len;
        service   = req & ~(wbs_we_i & is_data & full);
        pop       = m_tvalid & m_tready & ~flush;
    end

    // Register read mux, sampled from pre-edge state
    always_comb begin
        reg_rdata = '0;
        if (is_len) begin
            reg_rdata = {16'h0, len};
        end else if (is_status) begin
            reg_rdata = {beat, 9'h0, empty, full, count};
        end
        rdata_nx = (service & ~wbs_we_i) ? reg_rdata : '0;
    end

    // FIFO pointers and occupancy
    always_comb begin
        wr_ptr_nx = wr_ptr;
        rd_ptr_nx = rd_ptr;
        count_nx  = count;
        if (flush) begin
            wr_ptr_nx = '0;
            rd_ptr_nx = '0;
            count_nx  = '0;
        end else begin
            if (push) begin
                wr_ptr_nx = wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr_nx = rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_nx = count + CW'(1);
                2'b01:   count_nx = count - CW'(1);
                default: count_nx = count;
            endcase
        end
    end

    // Head word for the next cycle; a push into a drained FIFO bypasses the array
    always_comb begin
        head_nx = mem[rd_ptr_nx];
        if (count_nx == '0) begin
            head_nx = '0;
        end else if (push && (count_nx == CW'(1))) begin
            head_nx = wbs_dat_i;
        end
    end

    // Frame length register and beat counter
    always_comb begin
        len_nx  = len;
        beat_nx = beat;
        if (len_wr) begin
            if (wbs_sel_i[0]) begin
                len_nx[7:0] = wbs_dat_i[7:0];
            end
            if (wbs_sel_i[1]) begin
                len_nx[15:8] = wbs_dat_i[15:8];
            end
        end
        if (flush || len_wr) begin
            beat_nx = '0;
        end else if (pop) begin
            beat_nx = m_tlast ? '0 : beat + LW'(1);
        end
        tlast_nx = (len_nx != '0) && (beat_nx == len_nx - LW'(1));
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wbs_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            len       <= '0;
            beat      <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            m_tdata   <= '0;
        end else begin
            wr_ptr    <= wr_ptr_nx;
            rd_ptr    <= rd_ptr_nx;
            count     <= count_nx;
            len       <= len_nx;
            beat      <= beat_nx;
            wbs_ack_o <= service;
            wbs_dat_o <= rdata_nx;
            m_tvalid  <= (count_nx != '0);
            m_tlast   <= tlast_nx;
            m_tdata   <= head_nx;
        end
    end

endmodule

// File: tb/tb_wbs_axis_ingress.sv
// Bench for wbs_axis_ingress: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wbs_axis_ingress;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_cyc, wbs_stb, wbs_we;
    logic [3:0]  wbs_sel;
    logic [7:0]  wbs_adr;
    logic [31:0] wbs_dat;
    logic        wbs_ack;
    logic [31:0] wbs_rdat;
    logic        m_tvalid, m_tlast, m_tready;
    logic [31:0] m_tdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wbs_axis_ingress #(.DEPTH(DEPTH)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(wbs_cyc),
        .wbs_stb_i(wbs_stb),
        .wbs_we_i (wbs_we),
        .wbs_sel_i(wbs_sel),
        .wbs_adr_i(wbs_adr),
        .wbs_dat_i(wbs_dat),
        .wbs_ack_o(wbs_ack),
        .wbs_dat_o(wbs_rdat),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tdata  (m_tdata),
        .m_tready (m_tready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue, registers are plain variables
    logic [31:0] q[$];
    logic [15:0] mlen, mbeat;
    logic        mack;
    logic [31:0] mdat;
    logic        mreq, mfull, mempty, mpush, mpop, mflush, mlenwr, msvc, mtl;
    logic [31:0] mrd;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                mlen = '0;
                mbeat = '0;
                mack = 1'b0;
                mdat = '0;
            end else begin
                mfull  = (q.size() == DEPTH);
                mempty = (q.size() == 0);
                mreq   = wbs_cyc && wbs_stb && !mack;
                mpush  = mreq && wbs_we && (wbs_adr == 8'h00) && !mfull;
                mflush = mreq && wbs_we && (wbs_adr == 8'h08) && wbs_dat[0];
                mlenwr = mreq && wbs_we && (wbs_adr == 8'h04);
                msvc   = mreq && !(wbs_we && (wbs_adr == 8'h00) && mfull);
                mtl    = (mlen != 0) && (mbeat == mlen - 16'd1);
                mpop   = !mempty && m_tready && !mflush;
                if (wbs_adr == 8'h04)      mrd = {16'h0, mlen};
                else if (wbs_adr == 8'h08) mrd = {mbeat, 9'h0, mempty, mfull, 5'(q.size())};
                else                       mrd = '0;
                mdat = (msvc && !wbs_we) ? mrd : '0;
                mack = msvc;
                if (mflush) begin
                    q.delete();
                    mbeat = '0;
                end else begin
                    if (mpop) begin
                        void'(q.pop_front());
                        mbeat = mtl ? 16'd0 : mbeat + 16'd1;
                    end
                    if (mpush) q.push_back(wbs_dat);
                end
                if (mlenwr) begin
                    if (wbs_sel[0]) mlen[7:0] = wbs_dat[7:0];
                    if (wbs_sel[1]) mlen[15:8] = wbs_dat[15:8];
                    mbeat = '0;
                end
            end
        end
    end

    // Per-cycle comparison plus capture of accepted stream beats
    logic        cap = 1'b0;
    logic [31:0] seen[$];
    logic        seenl[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("ack", 32'(wbs_ack), 32'(mack));
                chk("rdata", wbs_rdat, mdat);
                chk("tvalid", 32'(m_tvalid), 32'(q.size() != 0));
                chk("tlast", 32'(m_tlast), 32'((mlen != 0) && (mbeat == mlen - 16'd1)));
                if (q.size() != 0) chk("tdata", m_tdata, q[0]);
                if (cap && m_tvalid && m_tready) begin
                    seen.push_back(m_tdata);
                    seenl.push_back(m_tlast);
                end
            end
        end
    end

    // m_tready driver: 0 = low, 1 = high, otherwise random per cycle
    int rmode = 0;
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Bus transaction; starts and ends 1 time unit after a rising edge
    task automatic wb_op(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int limit, input logic must, output logic [31:0] rdat, output logic got);
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = w; wbs_adr = a; wbs_dat = d; wbs_sel = s;
        got = 1'b0;
        rdat = '0;
        for (int n = 0; n < limit && !got; n++) begin
            @(negedge clk);
            if (wbs_ack) begin
                got = 1'b1;
                rdat = wbs_rdat;
            end
            @(posedge clk);
            #1;
        end
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
        if (must) chk("wb_ack_seen", 32'(got), 32'd1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic g;
        wb_op(1'b1, a, d, 4'hF, 40, 1'b1, r, g);
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] r);
        logic g;
        wb_op(1'b0, a, 32'h0, 4'hF, 40, 1'b1, r, g);
    endtask

    task automatic wait_seen(input int n);
        int k = 0;
        while (seen.size() < n && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("seen_count", 32'(seen.size()), 32'(n));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic        g;
        logic        any_tl;
        rst = 1'b1;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
        wbs_sel = '0; wbs_adr = '0; wbs_dat = '0;

        // Reset values
        @(negedge clk);
        chk("rst_ack", 32'(wbs_ack), 0);
        chk("rst_rdata", wbs_rdat, 0);
        chk("rst_tvalid", 32'(m_tvalid), 0);
        chk("rst_tlast", 32'(m_tlast), 0);
        chk("rst_tdata", m_tdata, 0);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        rd(8'h08, v);
        chk("status_after_reset", v, 32'h0000_0040);

        // Four-beat frame
        rmode = 0;
        wr(8'h04, 32'd4);
        wr(8'h00, 32'h11); wr(8'h00, 32'h22); wr(8'h00, 32'h33); wr(8'h00, 32'h44);
        seen.delete(); seenl.delete(); cap = 1'b1;
        rmode = 1;
        wait_seen(4);
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            chk("frame_data", seen[i], 32'h11 * (i + 1));
            chk("frame_tlast", 32'(seenl[i]), 32'(i == 3));
        end
        rmode = 0;
        rd(8'h08, v);
        chk("frame_status", v, 32'h0000_0040);

        // Fill to full, stall the ninth write, release one slot
        seen.delete(); seenl.delete();
        for (int i = 1; i <= 8; i++) wr(8'h00, 32'(i));
        rd(8'h08, v);
        chk("full_status", v, 32'h0000_0028);
        fork
            wb_op(1'b1, 8'h00, 32'd9, 4'hF, 20, 1'b1, v, g);
            begin
                repeat (3) @(posedge clk);
                #1 rmode = 1;
                @(posedge clk);
                #1 rmode = 0;
            end
        join
        rmode = 1;
        wait_seen(9);
        for (int i = 0; i < 9 && i < seen.size(); i++) chk("full_order", seen[i], 32'(i + 1));
        rmode = 0;

        // Pending write against a draining full FIFO
        seen.delete(); seenl.delete();
        for (int i = 0; i < 8; i++) wr(8'h00, 32'h100 + 32'(i));
        fork
            wb_op(1'b1, 8'h00, 32'h1AA, 4'hF, 20, 1'b1, v, g);
            begin
                @(posedge clk);
                #1 rmode = 1;
            end
        join
        wait_seen(9);
        for (int i = 0; i < 9 && i < seen.size(); i++)
            chk("drain_order", seen[i], (i < 8) ? 32'h100 + 32'(i) : 32'h1AA);

        // LEN = 0: twenty beats, never a tlast
        wr(8'h04, 32'd0);
        seen.delete(); seenl.delete();
        for (int i = 0; i < 20; i++) wr(8'h00, 32'hA000 + 32'(i));
        wait_seen(20);
        any_tl = 1'b0;
        foreach (seenl[i]) any_tl |= seenl[i];
        chk("len0_tlast", 32'(any_tl), 0);
        rmode = 0;
        cap = 1'b0;
        rd(8'h08, v);
        chk("len0_status", v, 32'h0014_0040);

        // Flush coinciding with a pop
        wr(8'h00, 32'h5); wr(8'h00, 32'h6); wr(8'h00, 32'h7);
        rmode = 1;
        wb_op(1'b1, 8'h08, 32'h1, 4'hF, 20, 1'b1, v, g);
        chk("flush_tvalid", 32'(m_tvalid), 0);
        rmode = 0;
        rd(8'h08, v);
        chk("flush_status", v, 32'h0000_0040);

        // Randomized traffic
        rmode = 2;
        for (int it = 0; it < 500; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 4)
                wb_op(1'b1, 8'h00, $urandom, 4'($urandom), int'($urandom_range(1, 30)), 1'b0, v, g);
            else if (r == 5)
                wb_op(1'b1, 8'h04, 32'($urandom_range(0, 5)), 4'($urandom), 5, 1'b1, v, g);
            else if (r == 6)
                wb_op(1'b0, 8'h08, $urandom, 4'hF, 5, 1'b1, v, g);
            else if (r == 7)
                wb_op(1'b1, 8'h08, {$urandom_range(0, 65535), 15'h0, 1'($urandom_range(0, 3) == 0)},
                      4'hF, 5, 1'b1, v, g);
            else if (r == 8)
                wb_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 4) * 4), $urandom, 4'hF, 5, 1'b1, v, g);
            else begin
                wbs_cyc = 1'b1; wbs_stb = 1'($urandom_range(0, 1) == 0) ? 1'b0 : 1'b0;
                wbs_we = 1'b1; wbs_adr = 8'h00; wbs_dat = $urandom;
                @(posedge clk);
                #1 wbs_cyc = 1'b0; wbs_we = 1'b0;
            end
        end
        rmode = 0;

        // Asynchronous reset with data queued and an ack in flight
        wr(8'h08, 32'h1);
        for (int i = 0; i < 5; i++) wr(8'h00, 32'hB0 + 32'(i));
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = 8'h08;
        @(posedge clk);
        #3;
        chk("pre_rst_ack", 32'(wbs_ack), 1);
        rst = 1'b1;
        #1;
        chk("async_ack", 32'(wbs_ack), 0);
        chk("async_rdata", wbs_rdat, 0);
        chk("async_tvalid", 32'(m_tvalid), 0);
        chk("async_tlast", 32'(m_tlast), 0);
        chk("async_tdata", m_tdata, 0);
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        rd(8'h08, v);
        chk("post_rst_status", v, 32'h0000_0040);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
